// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared types and constants for the character LCD sequencer.
//   state_e      top FSM state encoding
//   byte_ph_e    sub-phase inside INIT_WAIT / BYTE
//   wait_sel_e   which delay follows an init nibble
//   INIT_NIBS    power-on nibble list, INIT_BYTES init byte ROM (index 0 first)
package lcd_ctrl_pkg;
  typedef enum logic [2:0] {
    PWRUP, INIT_NIB, INIT_WAIT, INIT_BYTE, IDLE, BYTE, EXEC_WAIT
  } state_e;

  // PH_NIB1: a nibble is in flight; PH_WAIT: delay counter running;
  // PH_NIB2: low nibble of a byte in flight.
  typedef enum logic [1:0] {PH_NIB1, PH_WAIT, PH_NIB2} byte_ph_e;

  typedef enum logic [1:0] {W_INIT1, W_INIT2, W_CMD} wait_sel_e;

  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;

  localparam logic [3:0][3:0] INIT_NIBS  = {4'h2, 4'h3, 4'h3, 4'h3};
  localparam logic [3:0][7:0] INIT_BYTES = {8'h01, 8'h0C, 8'h06, 8'h28};

  function automatic wait_sel_e init_wait_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return W_INIT1;
      2'd1:    return W_INIT2;
      default: return W_CMD;
    endcase
  endfunction
endpackage

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: byte write request handshake from the UI to the LCD sequencer.
//   valid  request present        (master -> slave)
//   ready  byte can be accepted   (slave -> master)
//   rs     0 = command, 1 = data  (master -> slave)
//   data   byte to write          (master -> slave)
interface lcd_ctrl_if;
  logic       valid;
  logic       ready;
  logic       rs;
  logic [7:0] data;

  modport master (output valid, rs, data, input ready);
  modport slave  (input valid, rs, data, output ready);
endinterface

// File: rtl/lcd_nibble_wr.sv
// lcd_nibble_wr: writes one nibble to the LCD pins.
//   CLK12/rst_n   clock, async active-low reset
//   start         load nib/rs; this cycle's edge begins the setup cycle
//   nib, rs       nibble and register select to drive
//   done          high during the hold cycle (last cycle of the nibble)
//   LCD_E/LCD_RS/SF_D  LCD pins; RS/D are held until the next start
// Timeline from the setup cycle: 0 setup (E=0), 1..E_HIGH_CYC E=1, then hold.
module lcd_nibble_wr #(
  parameter int E_HIGH_CYC = 4
) (
  input  logic       CLK12,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] nib,
  input  logic       rs,
  output logic       done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic [3:0] SF_D
);
  localparam int PW = $clog2(E_HIGH_CYC + 2);

  logic          busy;
  logic [PW-1:0] ph;

  assign done = busy && (ph == PW'(E_HIGH_CYC + 1));

  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      ph     <= '0;
      LCD_E  <= 1'b0;
      LCD_RS <= 1'b0;
      SF_D   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      ph     <= '0;
      LCD_E  <= 1'b0;
      SF_D   <= nib;
      LCD_RS <= rs;
    end else if (busy) begin
      // E for the next cycle: high while the next phase is 1..E_HIGH_CYC
      LCD_E <= (ph < PW'(E_HIGH_CYC));
      if (done) busy <= 1'b0;
      else      ph   <= ph + 1'b1;
    end
  end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 4-bit LCD sequencer. Runs the power-on init, then
// writes bytes handed over the req handshake as two nibbles with all
// setup/hold/execution delays counted in CLK12 cycles.
//   CLK12, rst_n   clock, async active-low reset
//   req            slave side of lcd_ctrl_if (valid/ready/rs/data)
//   init_done      init sequence complete, sticky until reset
//   LCD_RS, LCD_E, SF_D  LCD pins (RW is tied low elsewhere)
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int PWRUP_CYC   = 240000,
  parameter int INIT1_CYC   = 50000,
  parameter int INIT2_CYC   = 1200,
  parameter int E_HIGH_CYC  = 4,
  parameter int NIB_GAP_CYC = 12,
  parameter int CMD_CYC     = 480,
  parameter int CLR_CYC     = 19800,
  parameter int CNT_W       = 18
) (
  input  logic       CLK12,
  input  logic       rst_n,
  lcd_ctrl_if.slave  req,
  output logic       init_done,
  output logic       LCD_RS,
  output logic       LCD_E,
  output logic [3:0] SF_D
);
  state_e           state, state_n;
  byte_ph_e         ph, ph_n;
  logic [CNT_W-1:0] dly, dly_n;
  logic [1:0]       idx, idx_n;
  logic             armed, armed_n;
  logic             rs_q, rs_n;
  logic [7:0]       data_q, data_n;
  logic             ready_q;
  logic             accept, long_exec;
  logic             nib_start, nib_rs, nib_done;
  logic [3:0]       nib_val;

  assign req.ready = ready_q;
  assign accept    = req.valid && ready_q;
  assign long_exec = !rs_q && (data_q == CLEAR || data_q == HOME);

  function automatic logic [CNT_W-1:0] init_wait_cyc(input logic [1:0] i);
    case (init_wait_sel(i))
      W_INIT1: return CNT_W'(INIT1_CYC - 1);
      W_INIT2: return CNT_W'(INIT2_CYC - 1);
      default: return CNT_W'(CMD_CYC - 1);
    endcase
  endfunction

  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      ph        <= PH_NIB1;
      dly       <= '0;
      idx       <= '0;
      armed     <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      ph        <= ph_n;
      dly       <= dly_n;
      idx       <= idx_n;
      armed     <= armed_n;
      rs_q      <= rs_n;
      data_q    <= data_n;
      ready_q   <= (state_n == IDLE);
      init_done <= init_done || (state_n == IDLE);
    end
  end

  always_comb begin
    state_n = state;
    ph_n    = ph;
    idx_n   = idx;
    armed_n = armed;
    rs_n    = rs_q;
    data_n  = data_q;
    dly_n   = (dly != '0) ? dly - 1'b1 : '0;
    case (state)
      // counter resets to 0, so the first cycle arms it; total is PWRUP_CYC
      PWRUP:
        if (!armed) begin
          armed_n = 1'b1;
          dly_n   = CNT_W'(PWRUP_CYC - 2);
        end else if (dly == '0) begin
          state_n = INIT_NIB;
          idx_n   = '0;
        end
      INIT_NIB: begin
        state_n = INIT_WAIT;
        ph_n    = PH_NIB1;
      end
      INIT_WAIT:
        if (ph == PH_NIB1) begin
          if (nib_done) begin
            ph_n  = PH_WAIT;
            dly_n = init_wait_cyc(idx);
          end
        end else if (dly == '0) begin
          idx_n   = idx + 2'd1;  // wraps to 0 for the byte ROM
          state_n = (idx == 2'd3) ? INIT_BYTE : INIT_NIB;
        end
      INIT_BYTE: begin
        rs_n    = 1'b0;
        data_n  = INIT_BYTES[idx];
        state_n = BYTE;
        ph_n    = PH_NIB1;
      end
      IDLE:
        if (accept) begin
          rs_n    = req.rs;
          data_n  = req.data;
          state_n = BYTE;
          ph_n    = PH_NIB1;
        end
      BYTE:
        case (ph)
          PH_NIB1:
            if (nib_done) begin
              ph_n  = PH_WAIT;
              dly_n = CNT_W'(NIB_GAP_CYC - 1);
            end
          PH_WAIT: if (dly == '0) ph_n = PH_NIB2;
          default:
            if (nib_done) begin
              state_n = EXEC_WAIT;
              dly_n   = long_exec ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
            end
        endcase
      EXEC_WAIT:
        if (dly == '0) begin
          if (init_done || idx == 2'd3) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + 2'd1;
            state_n = INIT_BYTE;
          end
        end
      default: state_n = PWRUP;
    endcase
  end

  // Nibble launches; the high nibble of a user byte starts on the accept edge
  always_comb begin
    nib_start = 1'b0;
    nib_val   = '0;
    nib_rs    = 1'b0;
    case (state)
      INIT_NIB: begin
        nib_start = 1'b1;
        nib_val   = INIT_NIBS[idx];
      end
      INIT_BYTE: begin
        nib_start = 1'b1;
        nib_val   = INIT_BYTES[idx][7:4];
      end
      IDLE:
        if (accept) begin
          nib_start = 1'b1;
          nib_val   = req.data[7:4];
          nib_rs    = req.rs;
        end
      BYTE:
        if (ph == PH_WAIT && dly == '0) begin
          nib_start = 1'b1;
          nib_val   = data_q[3:0];
          nib_rs    = rs_q;
        end
      default: ;
    endcase
  end

  lcd_nibble_wr #(.E_HIGH_CYC(E_HIGH_CYC)) u_nib (
    .CLK12  (CLK12),
    .rst_n  (rst_n),
    .start  (nib_start),
    .nib    (nib_val),
    .rs     (nib_rs),
    .done   (nib_done),
    .LCD_E  (LCD_E),
    .LCD_RS (LCD_RS),
    .SF_D   (SF_D)
  );
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl with shortened delays. Expected
// nibbles are queued when a byte is driven and popped on each E rising edge.
module tb_lcd_ctrl;
  localparam int E_HIGH = 2;
  localparam int CLR    = 15;

  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
  } nib_t;

  logic       CLK12 = 1'b0;
  logic       rst_n;
  logic       init_done, LCD_RS, LCD_E;
  logic [3:0] SF_D;

  lcd_ctrl_if req_if ();

  lcd_ctrl #(
    .PWRUP_CYC(20), .INIT1_CYC(10), .INIT2_CYC(6), .E_HIGH_CYC(E_HIGH),
    .NIB_GAP_CYC(3), .CMD_CYC(5), .CLR_CYC(CLR), .CNT_W(18)
  ) dut (
    .CLK12(CLK12), .rst_n(rst_n), .req(req_if), .init_done(init_done),
    .LCD_RS(LCD_RS), .LCD_E(LCD_E), .SF_D(SF_D)
  );

  always #5 CLK12 = ~CLK12;

  int   ncmp = 0, nerr = 0;
  int   cyc = 0, t_fall = 0, t_acc = 0, e_len = 0;
  logic e_prev = 1'b0;
  nib_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK12);
    #1;
  endtask

  task automatic push_byte(input logic r, input logic [7:0] d);
    exp_q.push_back('{rs: r, nib: d[7:4]});
    exp_q.push_back('{rs: r, nib: d[3:0]});
  endtask

  task automatic push_init();
    exp_q.push_back('{rs: 1'b0, nib: 4'h3});
    exp_q.push_back('{rs: 1'b0, nib: 4'h3});
    exp_q.push_back('{rs: 1'b0, nib: 4'h3});
    exp_q.push_back('{rs: 1'b0, nib: 4'h2});
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  // Scoreboard and E-width monitor
  always @(negedge CLK12) begin
    nib_t e;
    cyc++;
    if (!rst_n) begin
      e_prev = 1'b0;
    end else begin
      if (LCD_E && !e_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_e_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("nib_sf_d", 32'(SF_D), 32'(e.nib));
          check("nib_rs", 32'(LCD_RS), 32'(e.rs));
        end
        e_len = 1;
      end else if (LCD_E) begin
        e_len++;
      end else if (e_prev) begin
        check("e_high_cycles", e_len, E_HIGH);
        t_fall = cyc;
      end
      e_prev = LCD_E;
    end
  end

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 3000) begin
      check("ready_low_in_init", 32'(req_if.ready), 32'd0);
      tick();
      n++;
    end
    check("init_done_rise", 32'(init_done), 32'd1);
    // CLR wait cycles lie between the final hold cycle and init_done
    check("init_done_delay", cyc - t_fall - 1, CLR);
    check("ready_with_init_done", 32'(req_if.ready), 32'd1);
    check("init_seq_complete", exp_q.size(), 0);
  endtask

  task automatic wait_ready(input string tag, input int lat);
    int n = 0;
    while (!req_if.ready && n < 500) begin
      tick();
      n++;
    end
    check(tag, cyc - t_acc, lat);
  endtask

  task automatic send(input string tag, input logic r, input logic [7:0] d, input int lat);
    push_byte(r, d);
    req_if.rs    = r;
    req_if.data  = d;
    req_if.valid = 1'b1;
    t_acc = cyc;
    tick();
    req_if.valid = 1'b0;
    req_if.data  = 8'hA5;
    check("ready_drop", 32'(req_if.ready), 32'd0);
    wait_ready(tag, lat);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    req_if.valid = 1'b0;
    req_if.rs    = 1'b0;
    req_if.data  = 8'h00;
    repeat (3) tick();
    check("rst_lcd_e", 32'(LCD_E), 32'd0);
    check("rst_lcd_rs", 32'(LCD_RS), 32'd0);
    check("rst_sf_d", 32'(SF_D), 32'd0);
    check("rst_ready", 32'(req_if.ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);

    // Init sequence, with stray requests that must be ignored
    push_init();
    rst_n = 1'b1;
    repeat (5) tick();
    req_if.valid = 1'b1; req_if.rs = 1'b1; req_if.data = 8'hFF;
    tick();
    req_if.valid = 1'b0;
    repeat (25) tick();
    req_if.valid = 1'b1; req_if.data = 8'h33;
    repeat (2) tick();
    req_if.valid = 1'b0;
    wait_init();

    send("lat_data_41", 1'b1, 8'h41, 17);
    send("lat_cmd_clear", 1'b0, 8'h01, 27);
    send("lat_cmd_80", 1'b0, 8'h80, 17);
    send("lat_cmd_home", 1'b0, 8'h02, 27);
    send("lat_data_01", 1'b1, 8'h01, 17);

    // valid held with data changing: only the accept-cycle value is written
    push_byte(1'b1, 8'h55);
    req_if.rs = 1'b1; req_if.data = 8'h55; req_if.valid = 1'b1;
    t_acc = cyc;
    for (int b = 0; b < 2; b++) begin
      tick();
      check("held_ready_low", 32'(req_if.ready), 32'd0);
      n = 0;
      while (!req_if.ready && n < 500) begin
        req_if.data = 8'($urandom_range(0, 255));
        tick();
        n++;
      end
      check("held_latency", cyc - t_acc, 17);
      if (b == 0) begin
        push_byte(1'b1, req_if.data);
        t_acc = cyc;
      end else begin
        req_if.valid = 1'b0;
      end
    end

    // Reset while E is high mid-byte
    push_byte(1'b1, 8'h41);
    req_if.data = 8'h41; req_if.valid = 1'b1;
    tick();
    req_if.valid = 1'b0;
    n = 0;
    while (!LCD_E && n < 50) begin
      tick();
      n++;
    end
    check("e_high_before_reset", 32'(LCD_E), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_e_drop", 32'(LCD_E), 32'd0);
    check("reset_init_done", 32'(init_done), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    push_init();
    rst_n = 1'b1;
    tick();
    check("reinit_done_low", 32'(init_done), 32'd0);
    wait_init();
    send("lat_after_reinit", 1'b1, 8'h41, 17);

    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
